gpio_pad_ctrl: RTL and testbench

- Digital GPIO controller that sits directly in front of a pull-down bidirectional pad cell.
- It drives the pad's data input and output-enable (active-low, 1 = input) and consumes the pad's data output.
- The input path has a synchronizer, a debounce filter, edge detection and a sticky interrupt.
- The output path has registered drive and direction control, with reset forcing the pad to input so the pad pulldown holds it at 0.

---
 rtl/gpio_pad_ctrl.sv | 119 +++++++++++
 tb/tb_gpio_pad_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad controller: registered drive/direction toward a pull-down pad, plus a
// synchronized, debounced input path with edge pulses and a sticky interrupt.
// Optional open-source drive mode is enabled by defining GPIO_OPEN_SRC_EN.
module gpio_pad_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_LEN     = 4,
  parameter int DEB_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cfg_oe,
  input  logic cfg_dout,
`ifdef GPIO_OPEN_SRC_EN
  input  logic cfg_os,
`endif
  output logic pad_din,
  output logic pad_oen,
  input  logic pad_dout,
  output logic in_level,
  output logic rise_pulse,
  output logic fall_pulse,
  input  logic irq_en_rise,
  input  logic irq_en_fall,
  input  logic irq_clr,
  output logic irq
);

  localparam logic [DEB_W-1:0] CNT_MAX = DEB_W'(DEB_LEN - 1);

  logic                   pad_oen_reg, pad_oen_next;
  logic                   pad_din_reg, pad_din_next;
  logic                   src;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s;
  logic [DEB_W-1:0]       cnt_reg;
  logic                   level_reg;
  logic                   rise_reg;
  logic                   fall_reg;
  logic                   irq_reg;
  logic                   irq_set;

  always_comb begin
    pad_oen_next = ~cfg_oe;
    pad_din_next = cfg_dout;
`ifdef GPIO_OPEN_SRC_EN
    // Open-source: only ever drive a 1; a 0 releases the pad to its pulldown.
    if (cfg_os && cfg_oe) begin
      pad_oen_next = ~cfg_dout;
      pad_din_next = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pad_oen_reg <= 1'b1;
      pad_din_reg <= 1'b0;
    end else begin
      pad_oen_reg <= pad_oen_next;
      pad_din_reg <= pad_din_next;
    end
  end

  // The pad output is high-Z while driving, so output mode samples our own drive.
  assign src = pad_oen_reg ? pad_dout : pad_din_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], src};
    end
  end

  assign s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      if (s == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_MAX) begin
        level_reg <= s;
        cnt_reg   <= '0;
        rise_reg  <= s;
        fall_reg  <= ~s;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign irq_set = (rise_reg & irq_en_rise) | (fall_reg & irq_en_fall);

  // Set has priority over clear so an edge arriving with a clear is not lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_reg <= 1'b0;
    end else if (irq_set) begin
      irq_reg <= 1'b1;
    end else if (irq_clr) begin
      irq_reg <= 1'b0;
    end
  end

  assign pad_oen    = pad_oen_reg;
  assign pad_din    = pad_din_reg;
  assign in_level   = level_reg;
  assign rise_pulse = rise_reg;
  assign fall_pulse = fall_reg;
  assign irq        = irq_reg;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Scoreboard bench for gpio_pad_ctrl (default parameters): each scenario queues the
// expected {pad_oen,pad_din,in_level,rise,fall,irq} per cycle and compares as it clocks.
module tb_gpio_pad_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_oe = 1'b0;
  logic cfg_dout = 1'b0;
  logic pad_dout = 1'b0;
  logic irq_en_rise = 1'b0;
  logic irq_en_fall = 1'b0;
  logic irq_clr = 1'b0;
`ifdef GPIO_OPEN_SRC_EN
  logic cfg_os = 1'b0;
`endif
  logic pad_din, pad_oen, in_level, rise_pulse, fall_pulse, irq;

  int checks = 0;
  int failures = 0;
  logic [5:0] exp_q[$];

  always #5 clk = ~clk;

  gpio_pad_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_oe(cfg_oe),
    .cfg_dout(cfg_dout),
`ifdef GPIO_OPEN_SRC_EN
    .cfg_os(cfg_os),
`endif
    .pad_din(pad_din),
    .pad_oen(pad_oen),
    .pad_dout(pad_dout),
    .in_level(in_level),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .irq_en_rise(irq_en_rise),
    .irq_en_fall(irq_en_fall),
    .irq_clr(irq_clr),
    .irq(irq)
  );

  function automatic logic [5:0] obs();
    return {pad_oen, pad_din, in_level, rise_pulse, fall_pulse, irq};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] e, got;
    rst_n = 1'b0; cfg_oe = 1'b0; pad_dout = 1'b0;
    irq_en_rise = 1'b1; irq_en_fall = 1'b1;
    for (int i = 1; i <= 23; i++) exp_q.push_back(6'b100000);
    for (int i = 1; i <= 23; i++) begin
      rst_n = (i > 3);
      tick();
      e = exp_q.pop_front(); got = obs(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL reset cyc=%0d got=%b exp=%b", i, got, e);
      end
    end
  endtask

  task automatic test_rise();
    logic [5:0] e, got;
    irq_en_rise = 1'b1; irq_en_fall = 1'b0;
    pad_dout = 1'b1;
    for (int i = 1; i <= 9; i++)
      exp_q.push_back({1'b1, 1'b0, (i >= 6), (i == 6), 1'b0, (i >= 7)});
    for (int i = 1; i <= 9; i++) begin
      tick();
      e = exp_q.pop_front(); got = obs(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL rise cyc=%0d got=%b exp=%b", i, got, e);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [5:0] e, got;
    pad_dout = 1'b0;
    for (int i = 1; i <= 9; i++) exp_q.push_back(6'b100000);
    for (int i = 1; i <= 9; i++) begin
      rst_n = (i != 1);
      tick();
      e = exp_q.pop_front(); got = obs(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL mid_reset cyc=%0d got=%b exp=%b", i, got, e);
      end
    end
  endtask

  task automatic test_glitch();
    logic [5:0] e, got;
    logic [7:0] seq2;
    irq_en_rise = 1'b1; irq_en_fall = 1'b0;
    // Three-cycle pulse: count reaches DEB_LEN-1 but never fires.
    for (int i = 1; i <= 10; i++) exp_q.push_back(6'b100000);
    for (int i = 1; i <= 10; i++) begin
      pad_dout = (i <= 3);
      tick();
      e = exp_q.pop_front(); got = obs(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL glitch_short cyc=%0d got=%b exp=%b", i, got, e);
      end
    end
    seq2 = 8'b1111_0111;  // bit (i-1) applied before edge i: 1,1,1,0,1,1,1,1
    for (int i = 1; i <= 12; i++)
      exp_q.push_back({1'b1, 1'b0, (i >= 10), (i == 10), 1'b0, (i >= 11)});
    for (int i = 1; i <= 12; i++) begin
      pad_dout = (i <= 8) ? seq2[i-1] : 1'b1;
      tick();
      e = exp_q.pop_front(); got = obs(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL glitch_restart cyc=%0d got=%b exp=%b", i, got, e);
      end
    end
  endtask

  task automatic test_collision();
    logic [5:0] e, got;
    irq_clr = 1'b1;
    exp_q.push_back(6'b101000);
    tick();
    e = exp_q.pop_front(); got = obs(); checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL irq_clear got=%b exp=%b", got, e);
    end
    irq_en_rise = 1'b0; irq_en_fall = 1'b1; pad_dout = 1'b0;
    for (int i = 1; i <= 9; i++)
      exp_q.push_back({1'b1, 1'b0, (i < 6), 1'b0, (i == 6), (i == 7)});
    for (int i = 1; i <= 9; i++) begin
      irq_clr = (i == 7) || (i == 8);
      tick();
      e = exp_q.pop_front(); got = obs(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL collision cyc=%0d got=%b exp=%b", i, got, e);
      end
    end
    irq_clr = 1'b0;
  endtask

  task automatic test_loopback();
    logic [5:0] e, got;
    irq_en_rise = 1'b0; irq_en_fall = 1'b0;
    cfg_oe = 1'b1; cfg_dout = 1'b1; pad_dout = 1'b0;  // pad output ignored while driving
    for (int i = 1; i <= 9; i++)
      exp_q.push_back({1'b0, 1'b1, (i >= 7), (i == 7), 1'b0, 1'b0});
    for (int i = 1; i <= 9; i++) begin
      tick();
      e = exp_q.pop_front(); got = obs(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL loopback_out cyc=%0d got=%b exp=%b", i, got, e);
      end
    end
    irq_en_fall = 1'b1; cfg_oe = 1'b0;
    for (int i = 1; i <= 9; i++)
      exp_q.push_back({1'b1, 1'b1, (i < 7), 1'b0, (i == 7), (i >= 8)});
    for (int i = 1; i <= 9; i++) begin
      tick();
      e = exp_q.pop_front(); got = obs(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL loopback_in cyc=%0d got=%b exp=%b", i, got, e);
      end
    end
  endtask

`ifdef GPIO_OPEN_SRC_EN
  task automatic test_open_src();
    logic [5:0] e, got;
    irq_en_rise = 1'b0; irq_en_fall = 1'b0; irq_clr = 1'b1;
    cfg_os = 1'b1; cfg_oe = 1'b1; cfg_dout = 1'b1; pad_dout = 1'b0;
    for (int i = 1; i <= 9; i++)
      exp_q.push_back({1'b0, 1'b1, (i >= 7), (i == 7), 1'b0, 1'b0});
    for (int i = 1; i <= 9; i++) begin
      tick();
      e = exp_q.pop_front(); got = obs(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL open_src_high cyc=%0d got=%b exp=%b", i, got, e);
      end
    end
    cfg_dout = 1'b0;
    for (int i = 1; i <= 9; i++)
      exp_q.push_back({1'b1, 1'b1, (i < 7), 1'b0, (i == 7), 1'b0});
    for (int i = 1; i <= 9; i++) begin
      tick();
      e = exp_q.pop_front(); got = obs(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL open_src_release cyc=%0d got=%b exp=%b", i, got, e);
      end
    end
    irq_clr = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_rise();
    test_mid_reset();
    test_glitch();
    test_collision();
    test_loopback();
`ifdef GPIO_OPEN_SRC_EN
    test_open_src();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
